mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_wait_counter.sv | 32 +++
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and build defaults for the unified instruction/data memory arbiter.
package arm_mem_pkg;
  localparam int LATENCY_DEF         = 2;
  localparam int MAX_DATA_STREAK_DEF = 4;
  localparam int CNT_W               = 3;
  localparam int STREAK_W            = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter, master = pipeline and memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
  );
endinterface

// File: rtl/mem_wait_counter.sv
// Access-cycle counter: loaded with LATENCY on grant, counts down during ACCESS.
// last is high in the final access cycle (count == 1); no backpressure.
module mem_wait_counter import arm_mem_pkg::*; #(
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic last
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(LATENCY);
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data ports onto one memory; ready pulses LATENCY+1 cycles after grant.
// Requesters are held off via stall_f/stall_m until their one-cycle ready pulse.
module mem_arbiter import arm_mem_pkg::*; #(
  parameter int LATENCY         = LATENCY_DEF,
  parameter int MAX_DATA_STREAK = MAX_DATA_STREAK_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);
  state_e              state_q, state_d;
  gnt_e                gnt_q, gnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         dm_rdata_q, dm_rdata_d;
  logic                we_q, we_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                cnt_load, cnt_dec, cnt_last;
  logic                streak_full, fetch_wins;

  // Data has priority until it has starved a waiting fetch MAX_DATA_STREAK times.
  assign streak_full = (streak_q == STREAK_W'(MAX_DATA_STREAK));
  assign fetch_wins  = bus.if_req && (!bus.dm_req || streak_full);
  assign cnt_dec     = (state_q == ACCESS);

  mem_wait_counter #(.LATENCY(LATENCY)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .last  (cnt_last)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
    cnt_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          cnt_load = 1'b1;
          state_d  = ACCESS;
          if (fetch_wins) begin
            gnt_d    = GNT_IF;
            addr_d   = bus.if_addr;
            wdata_d  = '0;
            we_d     = 1'b0;
            streak_d = '0;
          end else begin
            gnt_d   = GNT_DM;
            addr_d  = bus.dm_addr;
            wdata_d = bus.dm_wdata;
            we_d    = bus.dm_we;
            if (bus.if_req && !streak_full) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        if (cnt_last) begin
          state_d = RESPOND;
          if (gnt_q == GNT_IF) begin
            if_rdata_d = bus.mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end
            dm_ready_d = 1'b1;
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
    end
  end

  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.dm_ready  = dm_ready_q;
  assign bus.stall_f   = bus.if_req && !if_ready_q;
  assign bus.stall_m   = bus.dm_req && !dm_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level reference model feeds a scoreboard queue.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.LATENCY(LAT), .MAX_DATA_STREAK(MAXS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          is_dm;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] data;
    int          due;
  } txn_t;

  txn_t        sbq[$];
  txn_t        act;
  bit          act_valid = 1'b0;
  int          act_t = 0;
  logic [31:0] phys_mem [256];
  logic [31:0] ref_mem  [256];
  logic [31:0] ref_if_last = '0;
  logic [31:0] ref_dm_last = '0;
  int          cyc = 0;
  int          free_at = 0;
  int          streak = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          exp_ifr, exp_dmr, in_win;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] raddr();
    logic [7:0] w;
    w = 8'($urandom);
    return {22'd0, w, 2'd0};
  endfunction

  // Memory environment: combinational read, write on each clock edge of a write access.
  assign bus.mem_rdata = phys_mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) phys_mem[bus.mem_addr[9:2]] = bus.mem_wdata;
  end

  // Reference model: one transfer at a time, LAT+2 cycles per transfer, streak-limited data priority.
  always @(posedge clk) begin : model
    txn_t e;
    bit   pick_if;
    if (!reset) begin
      sbq.delete();
      act_valid = 1'b0;
      streak    = 0;
      free_at   = 0;
    end else if (cyc >= free_at && (bus.if_req || bus.dm_req)) begin
      pick_if = bus.if_req && (!bus.dm_req || streak == MAXS);
      e.due   = cyc + LAT + 1;
      free_at = cyc + LAT + 2;
      if (pick_if) begin
        streak  = 0;
        e.is_dm = 1'b0;
        e.we    = 1'b0;
        e.addr  = bus.if_addr;
        e.wdata = '0;
        e.data  = ref_mem[bus.if_addr[9:2]];
      end else begin
        if (bus.if_req && streak < MAXS) streak++;
        e.is_dm = 1'b1;
        e.we    = bus.dm_we;
        e.addr  = bus.dm_addr;
        e.wdata = bus.dm_wdata;
        if (bus.dm_we) ref_mem[bus.dm_addr[9:2]] = bus.dm_wdata;
        e.data  = ref_mem[bus.dm_addr[9:2]];
      end
      sbq.push_back(e);
      act       = e;
      act_t     = cyc;
      act_valid = 1'b1;
    end
    cyc++;
  end

  // Monitor: samples on the falling edge, pops the scoreboard when a ready is due.
  always @(negedge clk) begin
    if (!reset) begin
      check("rst_mem_en",   32'(bus.mem_en),   32'd0);
      check("rst_mem_we",   32'(bus.mem_we),   32'd0);
      check("rst_if_ready", 32'(bus.if_ready), 32'd0);
      check("rst_dm_ready", 32'(bus.dm_ready), 32'd0);
      check("rst_mem_addr", bus.mem_addr,      32'd0);
      check("rst_mem_wdata", bus.mem_wdata,    32'd0);
      check("rst_if_rdata", bus.if_rdata,      32'd0);
      check("rst_dm_rdata", bus.dm_rdata,      32'd0);
      ref_if_last = '0;
      ref_dm_last = '0;
    end else begin
      exp_ifr = (sbq.size() > 0) && (sbq[0].due == cyc) && !sbq[0].is_dm;
      exp_dmr = (sbq.size() > 0) && (sbq[0].due == cyc) &&  sbq[0].is_dm;
      check("if_ready", 32'(bus.if_ready), 32'(exp_ifr));
      check("dm_ready", 32'(bus.dm_ready), 32'(exp_dmr));
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        txn_t e;
        e = sbq.pop_front();
        if (!e.is_dm)   ref_if_last = e.data;
        else if (!e.we) ref_dm_last = e.data;
      end
      check("if_rdata", bus.if_rdata, ref_if_last);
      check("dm_rdata", bus.dm_rdata, ref_dm_last);
      in_win = act_valid && (cyc >= act_t + 1) && (cyc <= act_t + LAT);
      check("mem_en", 32'(bus.mem_en), 32'(in_win));
      check("mem_we", 32'(bus.mem_we), 32'(in_win && act.we));
      if (in_win) check("mem_addr", bus.mem_addr, act.addr);
      if (in_win && act.we) check("mem_wdata", bus.mem_wdata, act.wdata);
      check("stall_f", 32'(bus.stall_f), 32'(bus.if_req && !exp_ifr));
      check("stall_m", 32'(bus.stall_m), 32'(bus.dm_req && !exp_dmr));
    end
  end

  // Request held until its ready; returns in the cycle after ready with req still asserted.
  task automatic fetch_txn(input logic [31:0] a);
    int n = 0;
    bus.if_req  = 1'b1;
    bus.if_addr = a;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.if_ready && n < 100);
    check("if_ready_timeout", 32'(bus.if_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic data_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.dm_ready && n < 100);
    check("dm_ready_timeout", 32'(bus.dm_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle_gap(input bit is_dm);
    int g;
    g = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
    if (g > 0) begin
      if (is_dm) bus.dm_req = 1'b0;
      else       bus.if_req = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = '0;
    bus.dm_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      phys_mem[i] = v;
      ref_mem[i]  = v;
    end
    phys_mem[32'h100 >> 2] = 32'hE3A00001;
    ref_mem[32'h100 >> 2]  = 32'hE3A00001;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // Single fetch, then simultaneous fetch and load.
    fetch_txn(32'h100);
    bus.if_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    fork
      begin fetch_txn(32'h104); bus.if_req = 1'b0; end
      begin data_txn(1'b0, 32'h200, 32'h0); bus.dm_req = 1'b0; end
    join
    repeat (2) begin @(posedge clk); #1; end

    // Store, then read it back.
    data_txn(1'b1, 32'h40, 32'hDEADBEEF);
    data_txn(1'b0, 32'h40, 32'h0);
    bus.dm_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Both ports requesting back to back: fetch gets one slot per MAXS data grants.
    fork
      begin repeat (6)  fetch_txn(raddr()); bus.if_req = 1'b0; end
      begin repeat (20) data_txn(1'b0, raddr(), 32'h0); bus.dm_req = 1'b0; end
    join
    repeat (2) begin @(posedge clk); #1; end

    // Reset during the first access cycle of a fetch; the held request restarts afterwards.
    fork
      begin fetch_txn(32'h100); bus.if_req = 1'b0; end
      begin
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b1;
      end
    join
    repeat (2) begin @(posedge clk); #1; end

    // Random traffic on both ports.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          fetch_txn(raddr());
          idle_gap(1'b0);
        end
        bus.if_req = 1'b0;
      end
      begin
        for (int j = 0; j < 40; j++) begin
          data_txn(1'($urandom_range(0, 1)), raddr(), $urandom);
          idle_gap(1'b1);
        end
        bus.dm_req = 1'b0;
      end
    join

    repeat (10) begin @(posedge clk); #1; end
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
